alu_arbiter: RTL and testbench

Two-port round-robin arbiter that shares one instance of the 16-bit `alu` between two independent requesters, e.g. the fetch/address unit and the execute unit of the micro core. Each port issues an operation with a valid/ready handshake and gets back a registered result and NZCV flags through its own single-entry response slot with a valid/ready handshake. One operation is granted per cycle, so ALU throughput is one op/cycle shared fairly.

---
 rtl/alu_pkg.sv | 14 +
 rtl/alu.sv | 41 ++++
 rtl/alu_arbiter.sv | 107 ++++++++++
 tb/tb_alu_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU op encodings and flag bit positions
package alu_pkg;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational add/sub/and/or ALU with NZCV flags
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [1:0]       i_op,
  output logic [WIDTH-1:0] o_result,
  output logic [3:0]       o_flags
);

  logic [WIDTH-1:0] w_b_eff;
  logic [WIDTH:0]   w_sum;
  logic             w_arith;

  // Subtract is a + ~b + 1, so carry out is the not-borrow.
  assign w_b_eff = i_op[0] ? ~i_b : i_b;
  assign w_sum   = {1'b0, i_a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, i_op[0]};
  assign w_arith = (i_op == ALU_ADD) || (i_op == ALU_SUB);

  always_comb begin
    o_result = w_sum[WIDTH-1:0];
    case (i_op)
      ALU_AND: o_result = i_a & i_b;
      ALU_OR:  o_result = i_a | i_b;
      default: o_result = w_sum[WIDTH-1:0];
    endcase
  end

  always_comb begin
    o_flags         = 4'b0000;
    o_flags[FLAG_N] = o_result[WIDTH-1];
    o_flags[FLAG_Z] = (o_result == '0);
    o_flags[FLAG_C] = w_arith && w_sum[WIDTH];
    o_flags[FLAG_V] = w_arith && (i_a[WIDTH-1] == w_b_eff[WIDTH-1]) &&
                      (w_sum[WIDTH-1] != i_a[WIDTH-1]);
  end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-port round-robin arbiter sharing one ALU
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [1:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [1:0]       req1_op,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_result,
  output logic [3:0]       rsp0_flags,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_result,
  output logic [3:0]       rsp1_flags,
  output logic             prio
);

  logic             w_elig0, w_elig1, w_grant0, w_grant1;
  logic [WIDTH-1:0] w_a, w_b, w_result;
  logic [1:0]       w_op;
  logic [3:0]       w_flags;

  logic             r_prio;
  logic             r_rsp0_valid, r_rsp1_valid;
  logic [WIDTH-1:0] r_rsp0_result, r_rsp1_result;
  logic [3:0]       r_rsp0_flags, r_rsp1_flags;

  // Work-conserving: priority only matters when both ports are eligible.
  always_comb begin
    w_elig0  = req0_valid && (!r_rsp0_valid || rsp0_ready) && !reset;
    w_elig1  = req1_valid && (!r_rsp1_valid || rsp1_ready) && !reset;
    w_grant0 = w_elig0 && (!w_elig1 || !r_prio);
    w_grant1 = w_elig1 && (!w_elig0 || r_prio);
  end

  assign w_a  = w_grant1 ? req1_a  : req0_a;
  assign w_b  = w_grant1 ? req1_b  : req0_b;
  assign w_op = w_grant1 ? req1_op : req0_op;

  alu #(.WIDTH(WIDTH)) u_alu (
    .i_a      (w_a),
    .i_b      (w_b),
    .i_op     (w_op),
    .o_result (w_result),
    .o_flags  (w_flags)
  );

  // After any grant, priority passes to the port that was not served.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prio <= 1'b0;
    end else if (w_grant0 || w_grant1) begin
      r_prio <= w_grant0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rsp0_valid  <= 1'b0;
      r_rsp0_result <= '0;
      r_rsp0_flags  <= 4'b0000;
    end else if (w_grant0) begin
      r_rsp0_valid  <= 1'b1;
      r_rsp0_result <= w_result;
      r_rsp0_flags  <= w_flags;
    end else if (rsp0_ready) begin
      r_rsp0_valid  <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rsp1_valid  <= 1'b0;
      r_rsp1_result <= '0;
      r_rsp1_flags  <= 4'b0000;
    end else if (w_grant1) begin
      r_rsp1_valid  <= 1'b1;
      r_rsp1_result <= w_result;
      r_rsp1_flags  <= w_flags;
    end else if (rsp1_ready) begin
      r_rsp1_valid  <= 1'b0;
    end
  end

  assign req0_ready  = w_grant0;
  assign req1_ready  = w_grant1;
  assign rsp0_valid  = r_rsp0_valid;
  assign rsp0_result = r_rsp0_result;
  assign rsp0_flags  = r_rsp0_flags;
  assign rsp1_valid  = r_rsp1_valid;
  assign rsp1_result = r_rsp1_result;
  assign rsp1_flags  = r_rsp1_flags;
  assign prio        = r_prio;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - randomized and directed checks of alu_arbiter against a reference model
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid, rsp0_ready, rsp1_ready;
  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, prio;
  logic [15:0] req0_a, req0_b, req1_a, req1_b, rsp0_result, rsp1_result;
  logic [1:0]  req0_op, req1_op;
  logic [3:0]  rsp0_flags, rsp1_flags;

  int          n_checks = 0;
  int          n_fail = 0;

  logic        m_valid [2];
  logic [15:0] m_res [2];
  logic [3:0]  m_flg [2];
  logic        m_prio;
  int          g_last;

  alu_arbiter #(.WIDTH(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_a      (req0_a),
    .req0_b      (req0_b),
    .req0_op     (req0_op),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_a      (req1_a),
    .req1_b      (req1_b),
    .req1_op     (req1_op),
    .rsp0_valid  (rsp0_valid),
    .rsp0_ready  (rsp0_ready),
    .rsp0_result (rsp0_result),
    .rsp0_flags  (rsp0_flags),
    .rsp1_valid  (rsp1_valid),
    .rsp1_ready  (rsp1_ready),
    .rsp1_result (rsp1_result),
    .rsp1_flags  (rsp1_flags),
    .prio        (prio)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference ALU from plain integer arithmetic; returns {flags, result}.
  function automatic logic [19:0] ref_alu(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    int ua, ub, sa, sb, full, s;
    logic c, v;
    logic [15:0] r;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    c = 1'b0;
    v = 1'b0;
    case (op)
      2'b00: begin full = ua + ub; s = sa + sb; c = full > 65535; v = (s > 32767) || (s < -32768); end
      2'b01: begin full = ua + (65535 - ub) + 1; s = sa - sb; c = full > 65535; v = (s > 32767) || (s < -32768); end
      2'b10: full = ua & ub;
      default: full = ua | ub;
    endcase
    r = 16'(full);
    return {r[15], (r == 16'h0000), c, v, r};
  endfunction

  function automatic int model_grant();
    bit e0, e1;
    e0 = req0_valid && (!m_valid[0] || rsp0_ready);
    e1 = req1_valid && (!m_valid[1] || rsp1_ready);
    if (reset) return -1;
    if (e0 && e1) return m_prio ? 1 : 0;
    if (e0) return 0;
    if (e1) return 1;
    return -1;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      m_valid[i] = 1'b0;
      m_res[i]   = 16'h0000;
      m_flg[i]   = 4'b0000;
    end
    m_prio = 1'b0;
  endtask

  task automatic check_outputs();
    check("rsp0_valid",  32'(rsp0_valid),  32'(m_valid[0]));
    check("rsp1_valid",  32'(rsp1_valid),  32'(m_valid[1]));
    check("rsp0_result", 32'(rsp0_result), 32'(m_res[0]));
    check("rsp1_result", 32'(rsp1_result), 32'(m_res[1]));
    check("rsp0_flags",  32'(rsp0_flags),  32'(m_flg[0]));
    check("rsp1_flags",  32'(rsp1_flags),  32'(m_flg[1]));
    check("prio",        32'(prio),        32'(m_prio));
  endtask

  // Called at a falling edge with inputs applied; returns at the next falling edge.
  task automatic cycle();
    int g;
    logic [19:0] r0, r1;
    bit k0, k1;
    #1;
    g = model_grant();
    check("req0_ready", 32'(req0_ready), 32'(g == 0));
    check("req1_ready", 32'(req1_ready), 32'(g == 1));
    r0 = ref_alu(req0_op, req0_a, req0_b);
    r1 = ref_alu(req1_op, req1_a, req1_b);
    k0 = rsp0_ready;
    k1 = rsp1_ready;
    @(posedge clk);
    if (g == 0) begin m_valid[0] = 1'b1; m_res[0] = r0[15:0]; m_flg[0] = r0[19:16]; end
    else if (k0) m_valid[0] = 1'b0;
    if (g == 1) begin m_valid[1] = 1'b1; m_res[1] = r1[15:0]; m_flg[1] = r1[19:16]; end
    else if (k1) m_valid[1] = 1'b0;
    if (g >= 0) m_prio = (g == 0);
    g_last = g;
    #1;
    check_outputs();
    @(negedge clk);
  endtask

  // Asynchronous reset pulse raised between edges while requests are pending.
  task automatic do_reset();
    #2;
    reset = 1'b1;
    #1;
    check("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
    check("rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
    check("rst_req0_ready", 32'(req0_ready), 32'd0);
    check("rst_req1_ready", 32'(req1_ready), 32'd0);
    check("rst_prio",       32'(prio),       32'd0);
    @(negedge clk);
    reset = 1'b0;
    model_clear();
  endtask

  function automatic logic [15:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return 16'h0000;
      1: return 16'h7FFF;
      2: return 16'h8000;
      3: return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    bit hold0, hold1;
    model_clear();
    reset = 1'b1;
    req0_valid = 1'b1; req0_a = 16'h7FFF; req0_b = 16'h0001; req0_op = 2'b00;
    req1_valid = 1'b0; req1_a = 16'h0000; req1_b = 16'h0000; req1_op = 2'b00;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    g_last = -1;

    @(negedge clk);
    check("init_req0_ready", 32'(req0_ready), 32'd0);
    check_outputs();
    @(negedge clk);
    reset = 1'b0;

    cycle();
    check("first_grant", 32'(g_last), 32'd0);
    check("add_result", 32'(rsp0_result), 32'h8000);
    check("add_flags",  32'(rsp0_flags),  32'h9);
    req0_op = 2'b01; req0_a = 16'h0005; req0_b = 16'h0005;
    cycle();
    check("sub_result", 32'(rsp0_result), 32'h0000);
    check("sub_flags",  32'(rsp0_flags),  32'h6);

    do_reset();
    req0_valid = 1'b1; req0_op = 2'b00; req0_a = 16'h1234; req0_b = 16'h4321;
    req1_valid = 1'b1; req1_op = 2'b10; req1_a = 16'h00F0; req1_b = 16'h0F0F;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("alt_grant", 32'(g_last), 32'(i % 2));
    end
    check("and_result", 32'(rsp1_result), 32'h0000);
    check("and_flags",  32'(rsp1_flags),  32'h4);

    do_reset();
    req1_valid = 1'b0; rsp0_ready = 1'b0;
    cycle();
    req1_valid = 1'b1; req1_op = 2'b00; req1_a = 16'h0101; req1_b = 16'h0202;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("blocked_grant", 32'(g_last), 32'd1);
    end
    rsp0_ready = 1'b1;
    #1;
    check("unblock_ready0", 32'(req0_ready), 32'd1);
    cycle();
    check("unblock_grant", 32'(g_last), 32'd0);

    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_op = 2'b11; req1_a = 16'hAAAA; req1_b = 16'h5555;
    cycle();
    check("or_result", 32'(rsp1_result), 32'hFFFF);
    check("or_flags",  32'(rsp1_flags),  32'h8);
    for (int i = 0; i < 4; i++) begin
      req1_op = 2'($urandom_range(0, 3)); req1_a = rand_operand(); req1_b = rand_operand();
      cycle();
      check("b2b_grant", 32'(g_last), 32'd1);
      check("b2b_valid", 32'(rsp1_valid), 32'd1);
    end

    req0_valid = 1'b1; req1_valid = 1'b1; rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    cycle();
    cycle();
    do_reset();
    cycle();
    check("post_reset_grant", 32'(g_last), 32'd0);

    hold0 = 1'b0;
    hold1 = 1'b0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    for (int n = 0; n < 400; n++) begin
      if (!hold0) begin
        req0_valid = ($urandom_range(0, 3) != 0);
        req0_op = 2'($urandom_range(0, 3)); req0_a = rand_operand(); req0_b = rand_operand();
      end
      if (!hold1) begin
        req1_valid = ($urandom_range(0, 3) != 0);
        req1_op = 2'($urandom_range(0, 3)); req1_a = rand_operand(); req1_b = rand_operand();
      end
      rsp0_ready = ($urandom_range(0, 9) < 7);
      rsp1_ready = ($urandom_range(0, 9) < 7);
      cycle();
      hold0 = req0_valid && (g_last != 0);
      hold1 = req1_valid && (g_last != 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
